// File: rtl/controle_acesso_memoria.sv
// controle_acesso_memoria: single-outstanding load/store sequencer between a
// datapath request/response handshake and a simple synchronous data memory.
// Each access costs one ACESSO cycle (memory strobe) and one RESPOSTA cycle
// (result presented). Back-to-back requests are accepted in RESPOSTA, which
// gives one access every two cycles.
module controle_acesso_memoria (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ReqValido,
    output logic       ReqPronto,
    input  logic       ReqEsc,
    input  logic [7:0] ReqEndereco,
    input  logic [7:0] ReqDado,
    output logic       RespValida,
    input  logic       RespPronto,
    output logic [7:0] RespDado,
    output logic [7:0] Endereco,
    output logic [7:0] DadoEscritoMem,
    output logic       EscMem,
    output logic       LerMem,
    input  logic [7:0] DadoLido,
    output logic [7:0] ContAcessos
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic       esc_q, esc_d;
    logic [7:0] end_q, end_d;
    logic [7:0] dado_q, dado_d;
    logic [7:0] resp_q, resp_d;
    logic [7:0] cont_q, cont_d;
    logic       aceita;

    // Request handshake: ready when idle, or when the pending response is
    // being consumed this cycle so a new request can follow immediately.
    always_comb begin
        ReqPronto = (estado_q == OCIOSO) || ((estado_q == RESPOSTA) && RespPronto);
        aceita    = ReqValido && ReqPronto;
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:   if (aceita) estado_d = ACESSO;
            ACESSO:   estado_d = RESPOSTA;
            RESPOSTA: if (RespPronto) estado_d = aceita ? ACESSO : OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    // Memory strobes and response valid are pure functions of the state
    always_comb begin
        EscMem     = (estado_q == ACESSO) && esc_q;
        LerMem     = (estado_q == ACESSO) && !esc_q;
        RespValida = (estado_q == RESPOSTA);
    end

    assign Endereco       = end_q;
    assign DadoEscritoMem = dado_q;
    assign RespDado       = resp_q;
    assign ContAcessos    = cont_q;

    // Request latch on acceptance; result capture and access count on ACESSO exit
    always_comb begin
        esc_d  = esc_q;
        end_d  = end_q;
        dado_d = dado_q;
        resp_d = resp_q;
        cont_d = cont_q;
        if (aceita) begin
            esc_d  = ReqEsc;
            end_d  = ReqEndereco;
            dado_d = ReqDado;
        end
        if (estado_q == ACESSO) begin
            // stores echo the written byte; loads take what the memory
            // produced on the falling edge of this cycle
            resp_d = esc_q ? dado_q : DadoLido;
            cont_d = cont_q + 8'd1;
        end
    end

    // State and datapath registers; reset wins over everything
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q <= OCIOSO;
            esc_q    <= 1'b0;
            end_q    <= 8'h00;
            dado_q   <= 8'h00;
            resp_q   <= 8'h00;
            cont_q   <= 8'h00;
        end else begin
            estado_q <= estado_d;
            esc_q    <= esc_d;
            end_q    <= end_d;
            dado_q   <= dado_d;
            resp_q   <= resp_d;
            cont_q   <= cont_d;
        end
    end

endmodule

// File: tb/tb_controle_acesso_memoria.sv
// Bench for controle_acesso_memoria: directed scenarios plus a random phase.
// A scoreboard entry is pushed per accepted request; a negedge monitor checks
// handshake, memory strobes and responses against a transaction-level model.
module tb_controle_acesso_memoria;

    logic       Clock, Reset, ReqValido, ReqPronto, ReqEsc;
    logic [7:0] ReqEndereco, ReqDado;
    logic       RespValida, RespPronto;
    logic [7:0] RespDado, Endereco, DadoEscritoMem, DadoLido, ContAcessos;
    logic       EscMem, LerMem;

    controle_acesso_memoria dut (
        .Clock(Clock), .Reset(Reset), .ReqValido(ReqValido), .ReqPronto(ReqPronto),
        .ReqEsc(ReqEsc), .ReqEndereco(ReqEndereco), .ReqDado(ReqDado),
        .RespValida(RespValida), .RespPronto(RespPronto), .RespDado(RespDado),
        .Endereco(Endereco), .DadoEscritoMem(DadoEscritoMem), .EscMem(EscMem),
        .LerMem(LerMem), .DadoLido(DadoLido), .ContAcessos(ContAcessos)
    );

    typedef struct {
        logic       esc;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [7:0] cnt;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    int         n_chk = 0;
    int         n_fail = 0;
    int         esc_pulses = 0;
    int         ler_pulses = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Memory attached to the DUT: write on rising edge, read on falling edge
    always @(posedge Clock) if (EscMem === 1'b1) env_mem[Endereco] <= DadoEscritoMem;
    always @(negedge Clock) if (LerMem === 1'b1) DadoLido <= env_mem[Endereco];

    // Strobe counters sampled on the rising edge
    always @(posedge Clock) begin
        if (EscMem === 1'b1) esc_pulses <= esc_pulses + 1;
        if (LerMem === 1'b1) ler_pulses <= ler_pulses + 1;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    // Monitor / reference model: one outstanding transaction, result visible
    // two edges after acceptance, strobe on the cycle in between.
    initial begin
        int         cyc;
        int         n_acc;
        logic [7:0] last_data, last_cnt;
        logic       exp_valid, exp_pronto, mem_act, esc_e;
        exp_t       e;
        cyc = 0; n_acc = 0; last_data = 8'h00; last_cnt = 8'h00;
        forever begin
            @(negedge Clock);
            cyc++;
            exp_valid  = (sb.size() != 0) && (cyc - sb[0].acc >= 2);
            mem_act    = (sb.size() != 0) && (cyc == sb[0].acc + 1);
            exp_pronto = (sb.size() == 0) || (exp_valid && RespPronto);
            esc_e      = 1'b0;
            if (mem_act) esc_e = sb[0].esc;
            chk("resp_valida", {7'b0, RespValida}, {7'b0, exp_valid});
            chk("req_pronto",  {7'b0, ReqPronto},  {7'b0, exp_pronto});
            chk("esc_mem",     {7'b0, EscMem},     {7'b0, mem_act && esc_e});
            chk("ler_mem",     {7'b0, LerMem},     {7'b0, mem_act && !esc_e});
            if (mem_act) begin
                chk("endereco", Endereco, sb[0].addr);
                chk("dado_escrito", DadoEscritoMem, sb[0].wdata);
            end
            if (exp_valid) begin
                chk("resp_dado", RespDado, sb[0].rdata);
                chk("cont_acessos", ContAcessos, sb[0].cnt);
            end else begin
                chk("resp_dado_hold", RespDado, last_data);
                chk("cont_hold", ContAcessos, last_cnt);
            end
            if (Reset) begin
                sb.delete();
                n_acc = 0; last_data = 8'h00; last_cnt = 8'h00;
            end else begin
                if (exp_valid && RespPronto) begin
                    last_data = sb[0].rdata;
                    last_cnt  = sb[0].cnt;
                    void'(sb.pop_front());
                end
                if (ReqValido && exp_pronto) begin
                    n_acc++;
                    e.esc   = ReqEsc;
                    e.addr  = ReqEndereco;
                    e.wdata = ReqDado;
                    if (ReqEsc) begin
                        ref_mem[ReqEndereco] = ReqDado;
                        e.rdata = ReqDado;
                    end else begin
                        e.rdata = ref_mem[ReqEndereco];
                    end
                    e.cnt = 8'(n_acc);
                    e.acc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int         e0, l0;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        DadoLido = 8'h00;
        Reset = 1'b1; ReqValido = 1'b0; ReqEsc = 1'b0;
        ReqEndereco = 8'h00; ReqDado = 8'h00; RespPronto = 1'b1;
        step(); step();
        chk("rst_endereco", Endereco, 8'h00);
        chk("rst_dado_escrito", DadoEscritoMem, 8'h00);
        chk("rst_resp_dado", RespDado, 8'h00);
        chk("rst_cont", ContAcessos, 8'h00);
        chk("rst_resp_valida", {7'b0, RespValida}, 8'h00);
        chk("rst_req_pronto", {7'b0, ReqPronto}, 8'h01);
        Reset = 1'b0;

        // Store 0x5A to 0x10, then load it back
        e0 = esc_pulses;
        ReqValido = 1'b1; ReqEsc = 1'b1; ReqEndereco = 8'h10; ReqDado = 8'h5A;
        step();
        chk("st_escmem", {7'b0, EscMem}, 8'h01);
        chk("st_endereco", Endereco, 8'h10);
        chk("st_dado", DadoEscritoMem, 8'h5A);
        ReqEsc = 1'b0; ReqDado = 8'hFF;
        step();
        chk("st_resp", RespDado, 8'h5A);
        step();
        ReqValido = 1'b0;
        step();
        chk("ld_valida", {7'b0, RespValida}, 8'h01);
        chk("ld_dado", RespDado, 8'h5A);
        chk("ld_cont", ContAcessos, 8'h02);
        chk("st_pulses", 8'(esc_pulses - e0), 8'h01);

        // Backpressure for 5 cycles with a request waiting that must be ignored
        step();
        ReqValido = 1'b1; ReqEsc = 1'b0; ReqEndereco = 8'h10; RespPronto = 1'b0;
        step();
        ReqValido = 1'b0;
        step();
        ReqValido = 1'b1; ReqEsc = 1'b1; ReqEndereco = 8'h99; ReqDado = 8'h33;
        e0 = esc_pulses; l0 = ler_pulses;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valida", {7'b0, RespValida}, 8'h01);
            chk("bp_dado", RespDado, 8'h5A);
            chk("bp_pronto", {7'b0, ReqPronto}, 8'h00);
            step();
        end
        ReqValido = 1'b0; RespPronto = 1'b1;
        step();
        chk("bp_idle_valida", {7'b0, RespValida}, 8'h00);
        chk("bp_idle_pronto", {7'b0, ReqPronto}, 8'h01);
        chk("bp_strobes", 8'((esc_pulses - e0) + (ler_pulses - l0)), 8'h00);
        chk("bp_cont", ContAcessos, 8'h03);

        // Back-to-back loads 0x00..0x03
        do_reset();
        ReqValido = 1'b1; ReqEsc = 1'b0; RespPronto = 1'b1; ReqEndereco = 8'h00;
        l0 = ler_pulses;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_ler_on", {7'b0, LerMem}, 8'h01);
            chk("b2b_end", Endereco, 8'(i));
            if (i == 3) ReqValido = 1'b0;
            else ReqEndereco = 8'(i + 1);
            step();
            v = 8'(i) ^ 8'hA5;
            chk("b2b_ler_off", {7'b0, LerMem}, 8'h00);
            chk("b2b_dado", RespDado, v);
        end
        step();
        chk("b2b_cont", ContAcessos, 8'h04);
        chk("b2b_pulses", 8'(ler_pulses - l0), 8'h04);

        // Counter wrap: 257 accesses from reset
        do_reset();
        ReqValido = 1'b1; RespPronto = 1'b1;
        for (int n = 0; n < 257; n++) begin
            ReqEsc = 1'($urandom_range(0, 1));
            ReqEndereco = 8'($urandom_range(64, 79));
            ReqDado = 8'($urandom);
            step(); step();
            if (n == 255) chk("wrap_00", ContAcessos, 8'h00);
            if (n == 256) chk("wrap_01", ContAcessos, 8'h01);
        end
        ReqValido = 1'b0;
        step();

        // Reset during the ACESSO cycle of a store
        do_reset();
        ReqValido = 1'b1; ReqEsc = 1'b1; ReqEndereco = 8'h20; ReqDado = 8'h77;
        step();
        chk("rma_escmem", {7'b0, EscMem}, 8'h01);
        Reset = 1'b1; ReqValido = 1'b0;
        step();
        Reset = 1'b0;
        chk("rma_escmem_off", {7'b0, EscMem}, 8'h00);
        chk("rma_valida", {7'b0, RespValida}, 8'h00);
        chk("rma_cont", ContAcessos, 8'h00);
        chk("rma_pronto", {7'b0, ReqPronto}, 8'h01);

        // Reset with a request held: accepted only after reset drops
        Reset = 1'b1; ReqValido = 1'b1; ReqEsc = 1'b1; ReqEndereco = 8'h30; ReqDado = 8'h11;
        step();
        chk("rv_no_accept", {7'b0, EscMem}, 8'h00);
        Reset = 1'b0;
        step();
        chk("rv_accept", {7'b0, EscMem}, 8'h01);
        chk("rv_end", Endereco, 8'h30);
        chk("rv_dado", DadoEscritoMem, 8'h11);
        ReqValido = 1'b0;
        step(); step();

        // Random traffic with sporadic resets
        for (int i = 0; i < 600; i++) begin
            Reset       = ($urandom_range(0, 79) == 0);
            ReqValido   = ($urandom_range(0, 3) != 0);
            RespPronto  = ($urandom_range(0, 2) != 0);
            ReqEsc      = 1'($urandom_range(0, 1));
            ReqEndereco = 8'($urandom_range(0, 15));
            ReqDado     = 8'($urandom);
            step();
        end
        Reset = 1'b0; ReqValido = 1'b0; RespPronto = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_acesso_memoria.md
CONTROLE_ACESSO_MEMORIA -- requirements
Module: controle_acesso_memoria

Interface
REQ-001 The block SHALL have no parameters; all data and address paths SHALL be 8 bits.
REQ-002 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 ReqValido  input  1  datapath presents a memory request.
REQ-005 ReqPronto  output  1  block can accept a request this cycle.
REQ-006 ReqEsc  input  1  1 = store, 0 = load.
REQ-007 ReqEndereco  input  8  request address.
REQ-008 ReqDado  input  8  store data; ignored for loads.
REQ-009 RespValida  output  1  response available.
REQ-010 RespPronto  input  1  datapath consumes the response this cycle.
REQ-011 RespDado  output  8  load result, or echo of the stored byte for stores.
REQ-012 Endereco  output  8  address to the data memory.
REQ-013 DadoEscritoMem  output  8  write data to the data memory.
REQ-014 EscMem  output  1  memory write enable; the memory writes on the rising edge.
REQ-015 LerMem  output  1  memory read enable; the memory reads on the falling edge.
REQ-016 DadoLido  input  8  memory read data, valid after the falling edge of an EscMem=0/LerMem=1 cycle.
REQ-017 ContAcessos  output  8  count of completed accesses.

Function
REQ-018 The FSM SHALL have exactly the states OCIOSO, ACESSO and RESPOSTA.
REQ-019 ReqPronto SHALL equal (state==OCIOSO) OR (state==RESPOSTA AND RespPronto).
REQ-020 A request SHALL be accepted on a rising edge where ReqValido and ReqPronto are both 1; on acceptance, ReqEsc, ReqEndereco and ReqDado SHALL be latched.
REQ-021 On acceptance the state SHALL go to ACESSO; with ReqValido=0 the state SHALL stay in OCIOSO.
REQ-022 In ACESSO, exactly one of EscMem or LerMem SHALL be 1, selected by the latched ReqEsc; in every other state, both SHALL be 0.
REQ-023 Endereco and DadoEscritoMem SHALL be driven from the latched registers and SHALL be stable for the whole ACESSO cycle.
REQ-024 ACESSO SHALL last exactly one cycle, then go to RESPOSTA.
REQ-025 On the ACESSO->RESPOSTA edge, RespDado SHALL load DadoLido for a load, or the latched store data for a store.
REQ-026 RespValida SHALL be 1 exactly while in RESPOSTA.
REQ-027 RespDado SHALL hold its value until the next ACESSO->RESPOSTA edge.
REQ-028 Latency SHALL be two rising edges from acceptance to RespValida=1.
REQ-029 In RESPOSTA with RespPronto=0, the state SHALL hold and all outputs SHALL be stable (backpressure).
REQ-030 In RESPOSTA with RespPronto=1, the state SHALL go to ACESSO if ReqValido=1 (new request latched), else to OCIOSO.
REQ-031 Sustained throughput SHALL be one access per two cycles.
REQ-032 ContAcessos SHALL increment by 1 on every ACESSO->RESPOSTA edge, wrapping from 255 to 0.
REQ-033 Request inputs SHALL be ignored when ReqPronto=0.

Reset
REQ-034 While Reset=1 at a rising edge, the state SHALL become OCIOSO.
REQ-035 Reset SHALL clear Endereco, DadoEscritoMem, RespDado and ContAcessos to 0x00.
REQ-036 Reset SHALL take priority over all other inputs at the same edge.
REQ-037 Reset during ACESSO or RESPOSTA SHALL abort the access: EscMem, LerMem and RespValida SHALL be 0 from the next cycle, and the pending response SHALL be discarded without incrementing ContAcessos.
REQ-038 ReqPronto SHALL be 1 in the first cycle after Reset deasserts.

Verification
REQ-039 Store then load: store 0x5A to address 0x10, then load address 0x10 -> EscMem=1 for exactly one cycle with Endereco=0x10 and DadoEscritoMem=0x5A; the load returns RespDado=0x5A two edges after acceptance; ContAcessos=2.
REQ-040 Backpressure: load completes with RespPronto=0 for 5 cycles -> RespValida and RespDado held constant, ReqPronto=0, no EscMem/LerMem pulses; on RespPronto=1 the state returns to OCIOSO.
REQ-041 Back-to-back: ReqValido and RespPronto held at 1 for four loads to addresses 0x00..0x03 -> LerMem pulses every second cycle; responses return in order; ContAcessos=4.
REQ-042 Wrap: 256 accesses from reset -> ContAcessos=0x00 after the 256th access and 0x01 after the 257th.
REQ-043 Reset mid-access: Reset asserted in the ACESSO cycle of a store to 0x20 -> the next cycle has EscMem=0, RespValida=0, ContAcessos=0 and ReqPronto=1.
REQ-044 Reset with ReqValido=1 held -> no acceptance on the reset edge; acceptance occurs on the first edge after Reset deasserts.
